// File: rtl/instr_encoder_if.sv
// instr_encoder_if: encode-request handshake and instruction-memory write bus.
interface instr_encoder_if #(parameter int ADDR_W = 8);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        op;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [12:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;
  modport master (
    output req_valid, op, rd, rs1, rs2, imm,
    input  req_ready, imem_we, imem_addr, imem_wdata, count, full, err
  );
  modport slave (
    input  req_valid, op, rd, rs1, rs2, imm,
    output req_ready, imem_we, imem_addr, imem_wdata, count, full, err
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: encodes RV32I instruction requests and streams them into instruction memory.
module instr_encoder #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  instr_encoder_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_t;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  state_t            state;
  logic [ADDR_W:0]   count;
  logic              err;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       enc;
  logic              acc;
  logic              legal;
  assign bus.req_ready  = rst_n && state != FULL && !clear;
  assign acc            = bus.req_valid && bus.req_ready;
  assign legal          = bus.op != 3'b111;
  assign bus.imem_we    = we;
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = wdata;
  assign bus.count      = count;
  assign bus.full       = state == FULL;
  assign bus.err        = err;
  always_comb begin
    enc = 32'h0;
    case (bus.op)
      3'b000: enc = {7'b0100000, bus.rs2, bus.rs1, 3'b000, bus.rd, 7'b0110011};
      3'b001: enc = {7'b0000000, bus.rs2, bus.rs1, 3'b100, bus.rd, 7'b0110011};
      3'b010: enc = {bus.imm[11:0], bus.rs1, 3'b010, bus.rd, 7'b0000011};
      3'b011: enc = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, 7'b0010011};
      3'b100: enc = {7'b0000000, bus.imm[4:0], bus.rs1, 3'b101, bus.rd, 7'b0010011};
      3'b101: enc = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010, bus.imm[4:0], 7'b0100011};
      3'b110: enc = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, 3'b000, bus.imm[4:1], bus.imm[11], 7'b1100011};
      default: enc = 32'h0;
    endcase
  end
  // addr/wdata only move on a legal accept so they hold through idle, illegal and clear cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      count <= '0;
      err   <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else if (clear) begin
      state <= EMPTY;
      count <= '0;
      err   <= 1'b0;
      we    <= 1'b0;
    end else begin
      we <= acc && legal;
      if (acc && !legal) err <= 1'b1;
      if (acc && legal) begin
        addr  <= count[ADDR_W-1:0];
        wdata <= enc;
        count <= count + 1'b1;
        state <= (count + 1'b1 == DEPTH_C) ? FULL : ACTIVE;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against a field-table encoding model.
module tb_instr_encoder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_count, m_addr;
  logic m_err, m_we;
  logic [31:0] m_wdata;
  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();
  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Encoding built from per-op opcode/funct tables and instruction-format field placement
  function automatic logic [31:0] ref_enc(input int o, input int rd, input int rs1, input int rs2, input int imm);
    int opc [7] = '{51, 51, 3, 19, 19, 35, 99};
    int f3  [7] = '{0, 4, 2, 0, 5, 2, 0};
    int ii;
    logic [31:0] base;
    ii = imm & 32'h1fff;
    base = (32'(rs1) << 15) | (32'(f3[o]) << 12) | 32'(opc[o]);
    if (o == 0) return base | (32'd32 << 25) | (32'(rs2) << 20) | (32'(rd) << 7);
    if (o == 1) return base | (32'(rs2) << 20) | (32'(rd) << 7);
    if (o == 2 || o == 3) return base | (32'(ii % 4096) << 20) | (32'(rd) << 7);
    if (o == 4) return base | (32'(ii % 32) << 20) | (32'(rd) << 7);
    if (o == 5) return base | (32'((ii / 32) % 128) << 25) | (32'(rs2) << 20) | (32'(ii % 32) << 7);
    return base | (32'((ii / 4096) % 2) << 31) | (32'((ii / 32) % 64) << 25) | (32'(rs2) << 20)
         | (32'((ii / 2) % 16) << 8) | (32'((ii / 2048) % 2) << 7);
  endfunction
  task automatic check_outputs(input string tag);
    chk({tag, ".we"}, 32'(bus.imem_we), 32'(m_we));
    chk({tag, ".addr"}, 32'(bus.imem_addr), 32'(m_addr));
    chk({tag, ".wdata"}, bus.imem_wdata, m_wdata);
    chk({tag, ".count"}, 32'(bus.count), 32'(m_count));
    chk({tag, ".full"}, 32'(bus.full), 32'(m_count == DEPTH));
    chk({tag, ".err"}, 32'(bus.err), 32'(m_err));
  endtask
  task automatic model_reset();
    m_count = 0; m_addr = 0; m_err = 1'b0; m_we = 1'b0; m_wdata = '0;
  endtask
  // One clock step: drive inputs, check ready, clock, update model, check outputs.
  task automatic step(input string tag, input bit v, input int o, input int rd, input int rs1,
                      input int rs2, input int imm, input bit clr);
    bit rdy;
    bus.req_valid = v; bus.op = 3'(o); bus.rd = 5'(rd); bus.rs1 = 5'(rs1);
    bus.rs2 = 5'(rs2); bus.imm = 13'(imm); clear = clr;
    #1;
    rdy = (m_count != DEPTH) && !clr;
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(rdy));
    @(posedge clk);
    #1;
    if (clr) begin
      m_count = 0; m_err = 1'b0; m_we = 1'b0;
    end else begin
      m_we = v && rdy && o != 7;
      if (v && rdy && o == 7) m_err = 1'b1;
      if (m_we) begin
        m_addr = m_count; m_wdata = ref_enc(o, rd, rs1, rs2, imm); m_count++;
      end
    end
    check_outputs(tag);
    bus.req_valid = 1'b0; clear = 1'b0;
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.op = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;
    model_reset();
    #2;
    check_outputs("reset");
    chk("reset.ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    step("addi", 1, 3, 1, 0, 9, 5, 0);
    chk("addi.const", bus.imem_wdata, 32'h00500093);
    step("sub", 1, 0, 3, 1, 2, 0, 0);
    chk("sub.const", bus.imem_wdata, 32'h402081B3);
    chk("sub.addr", 32'(bus.imem_addr), 32'd1);
    chk("sub.count", 32'(bus.count), 32'd2);
    step("idle", 0, 0, 0, 0, 0, 0, 0);
    step("clr0", 0, 0, 0, 0, 0, 0, 1);
    step("sw", 1, 5, 7, 1, 2, 8, 0);
    chk("sw.const", bus.imem_wdata, 32'h0020A423);
    step("beq", 1, 6, 9, 1, 2, -4, 0);
    chk("beq.const", bus.imem_wdata, 32'hFE208EE3);
    step("srli", 1, 4, 5, 5, 17, 3, 0);
    chk("srli.const", bus.imem_wdata, 32'h0032D293);
    step("clr1", 0, 0, 0, 0, 0, 0, 1);
    step("ill", 1, 7, 1, 2, 3, 4, 0);
    chk("ill.err", 32'(bus.err), 32'd1);
    chk("ill.we", 32'(bus.imem_we), 32'd0);
    step("after_ill", 1, 1, 4, 5, 6, 0, 0);
    step("idle_err", 0, 0, 0, 0, 0, 0, 0);
    chk("err.sticky", 32'(bus.err), 32'd1);
    step("clr2", 0, 0, 0, 0, 0, 0, 1);
    chk("clr.err", 32'(bus.err), 32'd0);
    for (int i = 0; i < 5; i++) step("fill", 1, 1, i, i + 1, i + 2, 0, 0);
    chk("fill.full", 32'(bus.full), 32'd1);
    chk("fill.count", 32'(bus.count), 32'd4);
    step("clr3", 0, 0, 0, 0, 0, 0, 1);
    step("refill", 1, 3, 2, 3, 0, 100, 0);
    chk("refill.addr", 32'(bus.imem_addr), 32'd0);
    step("clr_valid", 1, 3, 2, 3, 0, 7, 1);
    chk("clr_valid.we", 32'(bus.imem_we), 32'd0);
    step("pre_rst", 1, 0, 8, 9, 10, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("async_rst.ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    step("post_rst", 1, 2, 11, 12, 13, -100, 0);
    chk("post_rst.addr", 32'(bus.imem_addr), 32'd0);
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 8191),
           $urandom_range(0, 9) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
